// File: rtl/serial_paralelo_pkg.sv
// Shared types and default constants for the serial-to-parallel lane receiver.
// Contents: receiver state enum, default word width, comma, idle word and
// lock threshold used as parameter defaults by serial_paralelo_sync.
package serial_paralelo_pkg;

  // Receiver alignment state.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } sp_state_e;

  localparam int unsigned DEFAULT_WIDTH      = 8;
  localparam logic [7:0]  DEFAULT_COMMA      = 8'hBC;
  localparam logic [7:0]  DEFAULT_IDLE_WORD  = 8'h7C;
  localparam int unsigned DEFAULT_SYNC_COUNT = 4;

endpackage : serial_paralelo_pkg

// File: rtl/sp_comma_detector.sv
// Serial shift register and comma comparator for the lane receiver.
// Ports:
//   clk_32f     - bit clock, one serial bit per rising edge
//   reset       - asynchronous active-low reset
//   data_in     - serial data, MSB first
//   word_c      - candidate word {history, data_in} (combinational)
//   comma_hit_c - word_c equals COMMA (combinational)
module sp_comma_detector
  import serial_paralelo_pkg::*;
#(
  parameter int unsigned      WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] COMMA = WIDTH'(DEFAULT_COMMA)
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] word_c,
  output logic             comma_hit_c
);

  // Only the WIDTH-1 most recent bits are ever read back, so the oldest bit
  // of the shift register is not stored.
  logic [WIDTH-2:0] sr_q;

  assign word_c      = {sr_q, data_in};
  assign comma_hit_c = (word_c == COMMA);

  // Bit history.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= word_c[WIDTH-2:0];
    end
  end

endmodule : sp_comma_detector

// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel lane receiver with comma-based word alignment.
// Hunts for COMMA at any bit offset, confirms SYNC_COUNT consecutive aligned
// commas, then presents each completed word on data_out.
// Optional feature: define SP_RESYNC_EN to drop back to HUNT after
// SYNC_COUNT misaligned commas seen while ACTIVE.
// Ports:
//   clk_32f     - bit clock, one serial bit per rising edge
//   reset       - asynchronous active-low reset
//   data_in     - serial data, MSB first
//   data_out    - last completed non-comma word, or IDLE_WORD
//   valid_out   - data_out holds a data word received in ACTIVE
//   word_strobe - one-cycle pulse per word boundary in ALIGN/ACTIVE
//   active      - lane is aligned (ACTIVE)
module serial_paralelo_sync
  import serial_paralelo_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEFAULT_COMMA),
  parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(DEFAULT_IDLE_WORD),
  parameter int unsigned      SYNC_COUNT = DEFAULT_SYNC_COUNT
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             word_strobe,
  output logic             active
);

  localparam int unsigned      BIT_W    = $clog2(WIDTH);
  localparam int unsigned      CNT_W    = $clog2(SYNC_COUNT + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] SYNC_MAX = CNT_W'(SYNC_COUNT);

  sp_state_e        state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d, bit_next;
  logic [CNT_W-1:0] comma_cnt_q, comma_cnt_d, comma_inc;
  logic [WIDTH-1:0] data_d;
  logic             valid_d, strobe_d, active_d;
  logic             word_done;
  logic [WIDTH-1:0] word_c;
  logic             comma_hit_c;

`ifdef SP_RESYNC_EN
  logic [CNT_W-1:0] slip_cnt_q, slip_cnt_d, slip_inc;
  assign slip_inc = (slip_cnt_q == SYNC_MAX) ? slip_cnt_q : slip_cnt_q + CNT_W'(1);
`endif

  sp_comma_detector #(
    .WIDTH (WIDTH),
    .COMMA (COMMA)
  ) u_comma_detector (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .word_c      (word_c),
    .comma_hit_c (comma_hit_c)
  );

  assign word_done = (bit_cnt_q == LAST_BIT);
  assign bit_next  = word_done ? '0 : bit_cnt_q + BIT_W'(1);
  assign comma_inc = (comma_cnt_q == SYNC_MAX) ? comma_cnt_q : comma_cnt_q + CNT_W'(1);

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    data_d      = data_out;
    valid_d     = valid_out;
    strobe_d    = 1'b0;
`ifdef SP_RESYNC_EN
    slip_cnt_d  = slip_cnt_q;
`endif

    unique case (state_q)
      HUNT: begin
        // Locking on the edge that samples the last comma bit means the
        // following bit is bit 0 of the next word.
        bit_cnt_d = '0;
        if (comma_hit_c) begin
          comma_cnt_d = CNT_W'(1);
          state_d     = (SYNC_COUNT == 1) ? ACTIVE : ALIGN;
        end
      end

      ALIGN: begin
        bit_cnt_d = bit_next;
        if (word_done) begin
          strobe_d = 1'b1;
          if (comma_hit_c) begin
            comma_cnt_d = comma_inc;
            if (comma_inc == SYNC_MAX) begin
              state_d = ACTIVE;
            end
          end else begin
            comma_cnt_d = '0;
            bit_cnt_d   = '0;
            state_d     = HUNT;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_d = bit_next;
        if (word_done) begin
          strobe_d = 1'b1;
          if (comma_hit_c) begin
            data_d  = IDLE_WORD;
            valid_d = 1'b0;
          end else begin
            data_d  = word_c;
            valid_d = 1'b1;
          end
        end
`ifdef SP_RESYNC_EN
        // An aligned comma wins over the misaligned-comma count.
        if (word_done && comma_hit_c) begin
          slip_cnt_d = '0;
        end else if (comma_hit_c) begin
          slip_cnt_d = slip_inc;
          if (slip_inc == SYNC_MAX) begin
            slip_cnt_d  = '0;
            comma_cnt_d = '0;
            bit_cnt_d   = '0;
            data_d      = IDLE_WORD;
            valid_d     = 1'b0;
            state_d     = HUNT;
          end
        end
`endif
      end

      default: begin
        bit_cnt_d   = '0;
        comma_cnt_d = '0;
        data_d      = IDLE_WORD;
        valid_d     = 1'b0;
        state_d     = HUNT;
      end
    endcase

    active_d = (state_d == ACTIVE);
  end

  // State, counters and output registers.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_out    <= IDLE_WORD;
      valid_out   <= 1'b0;
      word_strobe <= 1'b0;
      active      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_out    <= data_d;
      valid_out   <= valid_d;
      word_strobe <= strobe_d;
      active      <= active_d;
    end
  end

`ifdef SP_RESYNC_EN
  // Misaligned-comma counter.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      slip_cnt_q <= '0;
    end else begin
      slip_cnt_q <= slip_cnt_d;
    end
  end
`endif

endmodule : serial_paralelo_sync

// File: tb/tb_serial_paralelo_sync.sv
// Self-checking bench for serial_paralelo_sync: directed scenarios plus a
// randomized bit stream, compared bit-by-bit against a behavioural model.
module tb_serial_paralelo_sync;

  localparam int unsigned W     = 8;
  localparam int unsigned SYNC  = 4;
  localparam int unsigned COMMA = 32'hBC;
  localparam int unsigned IDLE  = 32'h7C;
  localparam int unsigned MASK  = (1 << W) - 1;

  logic         clk_32f;
  logic         reset;
  logic         data_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         word_strobe;
  logic         active;

  int n_checks;
  int n_fail;

  // Model state: last W bits seen, lock status, bits since lock, counters.
  int unsigned win;
  bit          m_locked;
  bit          m_active;
  int unsigned m_since;
  int unsigned m_commas;
  int unsigned m_slips;
  int unsigned e_data;
  bit          e_valid;
  bit          e_strobe;

  serial_paralelo_sync #(
    .WIDTH      (W),
    .COMMA      (8'hBC),
    .IDLE_WORD  (8'h7C),
    .SYNC_COUNT (SYNC)
  ) dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .word_strobe (word_strobe),
    .active      (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    win      = 0;
    m_locked = 0;
    m_active = 0;
    m_since  = 0;
    m_commas = 0;
    m_slips  = 0;
    e_data   = IDLE;
    e_valid  = 0;
    e_strobe = 0;
  endtask

  // One received bit, applied to the behavioural receiver.
  task automatic model_bit(input bit b);
    bit boundary;
    bit is_comma;
    win      = ((win << 1) | 32'(b)) & MASK;
    is_comma = (win == COMMA);
    e_strobe = 0;
    if (!m_locked) begin
      if (is_comma) begin
        m_locked = 1;
        m_since  = 0;
        m_commas = 1;
        if (SYNC == 1) m_active = 1;
      end
    end else begin
      m_since++;
      boundary = (m_since % W == 0);
      if (boundary) e_strobe = 1;
      if (!m_active) begin
        if (boundary) begin
          if (is_comma) begin
            m_commas++;
            if (m_commas == SYNC) m_active = 1;
          end else begin
            m_locked = 0;
            m_commas = 0;
          end
        end
      end else begin
        if (boundary) begin
          e_data  = is_comma ? IDLE : win;
          e_valid = !is_comma;
        end
`ifdef SP_RESYNC_EN
        if (is_comma && boundary) begin
          m_slips = 0;
        end else if (is_comma) begin
          m_slips++;
          if (m_slips == SYNC) begin
            m_locked = 0;
            m_active = 0;
            m_commas = 0;
            m_slips  = 0;
            e_valid  = 0;
            e_data   = IDLE;
          end
        end
`endif
      end
    end
  endtask

  task automatic send_bit(input bit b);
    data_in = b;
    @(posedge clk_32f);
    #1;
    model_bit(b);
    check_eq("data_out", 32'(data_out), e_data);
    check_eq("valid_out", 32'(valid_out), 32'(e_valid));
    check_eq("word_strobe", 32'(word_strobe), 32'(e_strobe));
    check_eq("active", 32'(active), 32'(m_active));
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [W-1:0] wd;
    int unsigned  r;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    data_in  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_32f);
    #1;
    check_eq("rst_data_out", 32'(data_out), 32'h7C);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_strobe", 32'(word_strobe), 32'd0);
    check_eq("rst_active", 32'(active), 32'd0);
    reset = 1'b1;

    // Lock at offset 0, then a data word and an in-band comma.
    repeat (3) send_word(8'hBC);
    check_eq("t1_active_3rd", 32'(active), 32'd0);
    send_word(8'hBC);
    check_eq("t1_active_4th", 32'(active), 32'd1);
    send_word(8'h55);
    check_eq("t1_data", 32'(data_out), 32'h55);
    check_eq("t1_valid", 32'(valid_out), 32'd1);
    check_eq("t1_strobe", 32'(word_strobe), 32'd1);
    send_word(8'hBC);
    check_eq("t4_idle", 32'(data_out), 32'h7C);
    check_eq("t4_valid", 32'(valid_out), 32'd0);
    check_eq("t4_strobe", 32'(word_strobe), 32'd1);
    send_word(8'h5A);
    send_bit(1'b1);
    check_eq("t4_strobe_low", 32'(word_strobe), 32'd0);
    check_eq("t4_hold", 32'(data_out), 32'h5A);

    // Asynchronous reset mid-word while ACTIVE.
    send_bit(1'b0);
    #2;
    reset = 1'b0;
    #2;
    check_eq("t5_data", 32'(data_out), 32'h7C);
    check_eq("t5_valid", 32'(valid_out), 32'd0);
    check_eq("t5_active", 32'(active), 32'd0);
    model_reset();
    #2;
    reset = 1'b1;
    repeat (3) send_word(8'hBC);
    check_eq("t5_relock_3rd", 32'(active), 32'd0);
    send_word(8'hBC);
    check_eq("t5_relock_4th", 32'(active), 32'd1);

    // Lock at bit offset 3.
    do_reset();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (4) send_word(8'hBC);
    check_eq("t2_active", 32'(active), 32'd1);
    wd = 8'hA3;
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(wd[i]);
      if (i == 1) check_eq("t2_before", 32'(data_out), 32'h7C);
    end
    check_eq("t2_data", 32'(data_out), 32'hA3);

    // A non-comma during ALIGN restarts the hunt.
    do_reset();
    send_word(8'hBC);
    send_word(8'hBC);
    send_word(8'h11);
    repeat (3) send_word(8'hBC);
    check_eq("t3_not_yet", 32'(active), 32'd0);
    send_word(8'hBC);
    check_eq("t3_active", 32'(active), 32'd1);

`ifdef SP_RESYNC_EN
    // Shift the stream by one bit: misaligned commas force a relock.
    send_bit(1'b0);
    repeat (3) send_word(8'hBC);
    check_eq("t6_still_active", 32'(active), 32'd1);
    send_word(8'hBC);
    check_eq("t6_dropped", 32'(active), 32'd0);
    check_eq("t6_valid", 32'(valid_out), 32'd0);
    repeat (3) send_word(8'hBC);
    check_eq("t6_not_yet", 32'(active), 32'd0);
    send_word(8'hBC);
    check_eq("t6_relocked", 32'(active), 32'd1);
`endif

    // Randomized stream: commas, data words, bit slips and resets.
    do_reset();
    for (int s = 0; s < 500; s++) begin
      r = $urandom_range(0, 39);
      if (r < 14) begin
        send_word(8'hBC);
      end else if (r < 18) begin
        repeat (SYNC) send_word(8'hBC);
      end else if (r < 32) begin
        send_word(8'($urandom));
      end else if (r < 39) begin
        repeat ($urandom_range(1, 7)) send_bit(1'($urandom));
      end else begin
        do_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_serial_paralelo_sync

// File: doc/serial_paralelo_sync.md
# serial_paralelo_sync

Parametrised serial-to-parallel receiver for the PCIe physical-layer lane path. It deserialises a single-bit stream, MSB first, in the `clk_32f` domain and finds word alignment by hunting for a comma pattern. It declares the lane active after `SYNC_COUNT` consecutive aligned commas, then emits parallel words with a valid flag and a one-cycle word strobe. It replaces the fixed 8-bit, two-clock converter with a single-clock, width-generic block.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥4.
- `COMMA`, 8'hBC: alignment pattern, `WIDTH` bits.
- `IDLE_WORD`, 8'h7C: value driven on `data_out` when no valid data is present.
- `SYNC_COUNT`, 4: number of consecutive aligned commas needed to reach ACTIVE; must be ≥1.

- `clk_32f`  in  1  bit clock; one serial bit is sampled per rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_in`  in  1  serial data, MSB first.
- `data_out`  out  WIDTH  last completed word, or `IDLE_WORD`.
- `valid_out`  out  1  `data_out` holds a non-comma word received in ACTIVE.
- `word_strobe`  out  1  one-cycle pulse at each word boundary while in ALIGN or ACTIVE.
- `active`  out  1  high in ACTIVE.

## Operation
- Shift register `sr[WIDTH-1:0]` loads `{sr[WIDTH-2:0], data_in}` on every edge.
- Candidate word `w` is the combinational value `{sr[WIDTH-2:0], data_in}`.
- `bit_cnt` runs 0..WIDTH-1. A word completes on the edge where `bit_cnt == WIDTH-1`.

State machine:
- HUNT
  - Compares `w` against `COMMA` on every edge. `bit_cnt` is frozen at 0.
  - On a match: `bit_cnt` ← 0 (the next bit is bit 0 of the next word) and `comma_cnt` ← 1.
  - On a match with `SYNC_COUNT == 1`: go to ACTIVE.
  - On a match with `SYNC_COUNT > 1`: go to ALIGN.
- ALIGN
  - `bit_cnt` increments and wraps.
  - On word completion with `w == COMMA`: `comma_cnt`++. When `comma_cnt` reaches `SYNC_COUNT`, go to ACTIVE.
  - On word completion with `w != COMMA`: `comma_cnt` ← 0 and go to HUNT.
- ACTIVE
  - On each word completion, `word_strobe` ← 1.
  - If `w == COMMA`: `data_out` ← `IDLE_WORD`, `valid_out` ← 0.
  - Otherwise: `data_out` ← `w`, `valid_out` ← 1.
  - Without the resync feature, the block stays in ACTIVE until reset.
- Between boundaries, `data_out` and `valid_out` hold their values. `word_strobe` is low.
- In HUNT and ALIGN: `valid_out` = 0 and `data_out` = `IDLE_WORD`.
- `comma_cnt` saturates at `SYNC_COUNT`; its width is `$clog2(SYNC_COUNT+1)`.

## Timing
- Reset values: `data_out` = `IDLE_WORD`, `valid_out` = 0, `word_strobe` = 0, `active` = 0, state = HUNT, `sr` = 0, `bit_cnt` = 0, `comma_cnt` = 0.
- All outputs are registered and update on the edge that samples the last bit of a word.
- Latency is 0 cycles after that edge: the value is visible for the following cycle.
- `active` rises on the same edge as the `SYNC_COUNT`-th aligned comma completes. The first data word follows `WIDTH` cycles later.
- `reset` asserted mid-word or mid-state: everything clears immediately, asynchronously, to the reset values. After release, HUNT restarts from bit 0.
- The comma may arrive at any bit offset after reset. HUNT locks at the edge where the last comma bit is sampled, so there are no slip cycles.

## Configuration
- `SP_RESYNC_EN` defined:
  - In ACTIVE, a misaligned comma (`w == COMMA` while `bit_cnt != WIDTH-1`) increments `slip_cnt`.
  - An aligned comma clears `slip_cnt`.
  - When `slip_cnt` reaches `SYNC_COUNT`, the block goes to HUNT and clears `active`, `valid_out` and both counters.
  - If a misaligned comma and a word completion coincide, the completion takes precedence.
- Undefined: there is no `slip_cnt` register. ACTIVE is left only by reset.

## Structure
- `serial_paralelo_pkg` holds:
  - the state enum (HUNT, ALIGN, ACTIVE);
  - the default `COMMA` and `IDLE_WORD` constants;
  - the default `SYNC_COUNT`.
- Sub-module `sp_comma_detector` contains the shift register, forms `w`, and outputs `comma_hit`. The parent holds the FSM, the counters and the output registers.

## Test plan
- After reset, send 0xBC ×4 at bit offset 0, then 0x55 → `active` rises on the 4th comma; next boundary gives `data_out` = 0x55, `valid_out` = 1, `word_strobe` pulse.
- Send 3 junk bits, then 0xBC ×4, then 0xA3 → lock at offset 3; `data_out` = 0xA3 exactly 8 cycles after `active` rises.
- Send 0xBC ×2, then 0x11, then 0xBC ×4 → the 0x11 forces a return to HUNT with `comma_cnt` = 0; `active` rises only after the last 4 commas.
- In ACTIVE, send 0xBC → `data_out` = 0x7C, `valid_out` = 0, `word_strobe` = 1.
- Assert `reset` low at mid-word in ACTIVE → all outputs reach their reset values with no clock edge; 0xBC ×4 is needed again after release.
- With `SP_RESYNC_EN`, shift the stream by 1 bit and send 0xBC ×4 → `active` falls after the 4th misaligned comma, then relocks after 4 more commas.
